mem_access: RTL



---
 rtl/mem_access_pkg.sv | 75 +++++++
 rtl/mem_access_load_align.sv | 27 ++
 rtl/mem_access.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-access stage.
package mem_access_pkg;

   localparam int DATA_W = 32;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [31:0]       instr_t;

   // Result presented to writeback when there is nothing to return
   localparam data_t NULL = '0;

   // Major opcodes of the base integer ISA
   typedef enum logic [6:0] {
      OP_LOAD     = 7'b0000011,
      OP_MISC_MEM = 7'b0001111,
      OP_OP_IMM   = 7'b0010011,
      OP_AUIPC    = 7'b0010111,
      OP_STORE    = 7'b0100011,
      OP_OP       = 7'b0110011,
      OP_LUI      = 7'b0110111,
      OP_BRANCH   = 7'b1100011,
      OP_JALR     = 7'b1100111,
      OP_JAL      = 7'b1101111,
      OP_SYSTEM   = 7'b1110011
   } opcode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   // Load width/extension selects
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Store width selects
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // Byte-enable patterns before lane shifting
   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   // An access is unusable if its width does not fit its lane, or if the
   // width select is not one the ISA defines for that opcode.
   function automatic logic isMisaligned(input logic       isStore,
                                         input logic [2:0] funct3,
                                         input logic [1:0] lane);
      logic bad;
      bad = 1'b1;
      if (isStore) begin
         case (funct3)
            F3_SB:   bad = 1'b0;
            F3_SH:   bad = lane[0];
            F3_SW:   bad = (lane != 2'b00);
            default: bad = 1'b1;
         endcase
      end else begin
         case (funct3)
            F3_LB, F3_LBU: bad = 1'b0;
            F3_LH, F3_LHU: bad = lane[0];
            F3_LW:         bad = (lane != 2'b00);
            default:       bad = 1'b1;
         endcase
      end
      return bad;
   endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Picks the addressed byte/half out of a read word and extends it.
module load_align
   import mem_access_pkg::*;
(
   input  data_t      rdata_i,
   input  logic [2:0] funct3_i,
   input  logic [1:0] lane_i,
   output data_t      data_o
);

   logic [7:0]  byteSel;
   logic [15:0] halfSel;

   // Lane select followed by sign or zero extension chosen by funct3
   always_comb begin
      byteSel = rdata_i[8*lane_i +: 8];
      halfSel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (funct3_i)
         F3_LB:   data_o = {{24{byteSel[7]}}, byteSel};
         F3_LBU:  data_o = {24'd0, byteSel};
         F3_LH:   data_o = {{16{halfSel[15]}}, halfSel};
         F3_LHU:  data_o = {16'd0, halfSel};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// Memory stage: turns loads/stores into a req/ack data-memory transaction,
// aligns load data and hands a registered result to writeback.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int          XLEN    = 32,
   parameter int unsigned TIMEOUT = 255
)
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   valid_in,
   input  instr_t instr,
   input  data_t  alu_result,
   input  data_t  rs2_data,
   output logic   stall,
   output logic   valid_out,
   output data_t  mem_data,
   output logic   misalign,
   output logic   bus_err,
   output logic   dmem_req,
   output logic   dmem_we,
   output data_t  dmem_addr,
   output logic [3:0] dmem_be,
   output data_t  dmem_wdata,
   input  data_t  dmem_rdata,
   input  logic   dmem_ack
);

   // Counter just wide enough to reach TIMEOUT; a zero TIMEOUT never fires
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

   mem_state_t       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             validOut_q, validOut_d;
   data_t            memData_q, memData_d;
   logic             misalign_q, misalign_d;
   logic             busErr_q, busErr_d;
   logic             req_q, req_d;
   logic             we_q, we_d;
   data_t            addr_q, addr_d;
   logic [3:0]       be_q, be_d;
   data_t            wdata_q, wdata_d;
   logic [2:0]       funct3_q, funct3_d;
   logic [1:0]       lane_q, lane_d;

   opcode_t          opcode;
   logic [2:0]       funct3;
   logic [1:0]       lane;
   logic             isLoad;
   logic             isStore;
   logic             badAccess;
   logic [3:0]       beReq;
   data_t            wdataReq;
   data_t            alignedData;
   logic [CNT_W-1:0] countInc;
   logic             unusedBits;

   // Fields of the instruction this stage does not look at
   assign unusedBits = ^{instr[31:15], instr[11:7]};

   load_align u_load_align (
      .rdata_i  (dmem_rdata),
      .funct3_i (funct3_q),
      .lane_i   (lane_q),
      .data_o   (alignedData)
   );

   // Decode the incoming instruction into byte enables and lane-replicated write data
   always_comb begin
      opcode    = opcode_t'(instr[6:0]);
      funct3    = instr[14:12];
      lane      = alu_result[1:0];
      isLoad    = (opcode == OP_LOAD);
      isStore   = (opcode == OP_STORE);
      badAccess = isMisaligned(isStore, funct3, lane);
      beReq     = BE_WORD;
      wdataReq  = rs2_data;
      if (isStore) begin
         case (funct3)
            F3_SB: begin
               beReq    = BE_BYTE << lane;
               wdataReq = {4{rs2_data[7:0]}};
            end
            F3_SH: begin
               beReq    = BE_HALF << {lane[1], 1'b0};
               wdataReq = {2{rs2_data[15:0]}};
            end
            default: begin
               beReq    = BE_WORD;
               wdataReq = rs2_data;
            end
         endcase
      end
   end

   // Upstream is held while a bus cycle is being launched or is outstanding
   always_comb begin
      stall = (state_q == REQ) ||
              ((state_q == IDLE) && valid_in && (isLoad || isStore) && !badAccess);
   end

   // Next-state and next-output logic; outputs are pulses unless explicitly held
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      countInc   = count_q + 1'b1;
      validOut_d = 1'b0;
      memData_d  = NULL;
      misalign_d = 1'b0;
      busErr_d   = 1'b0;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      funct3_d   = funct3_q;
      lane_d     = lane_q;
      case (state_q)
         IDLE: begin
            count_d = '0;
            if (valid_in) begin
               if ((isLoad || isStore) && !badAccess) begin
                  req_d    = 1'b1;
                  we_d     = isStore;
                  addr_d   = {alu_result[XLEN-1:2], 2'b00};
                  be_d     = beReq;
                  wdata_d  = wdataReq;
                  funct3_d = funct3;
                  lane_d   = lane;
                  state_d  = REQ;
               end else if (isLoad || isStore) begin
                  validOut_d = 1'b1;
                  misalign_d = 1'b1;
               end else begin
                  validOut_d = 1'b1;
               end
            end
         end
         REQ: begin
            if (dmem_ack) begin
               req_d      = 1'b0;
               validOut_d = 1'b1;
               memData_d  = we_q ? NULL : alignedData;
               state_d    = DONE;
            end else if ((TIMEOUT != 0) && (countInc == TIMEOUT_CNT)) begin
               req_d      = 1'b0;
               validOut_d = 1'b1;
               busErr_d   = 1'b1;
               state_d    = DONE;
            end else begin
               count_d = countInc;
            end
         end
         DONE: begin
            count_d = '0;
            state_d = IDLE;
         end
         default: begin
            req_d   = 1'b0;
            count_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State, counter and registered outputs; reset abandons any transaction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         count_q    <= '0;
         validOut_q <= 1'b0;
         memData_q  <= NULL;
         misalign_q <= 1'b0;
         busErr_q   <= 1'b0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
         funct3_q   <= '0;
         lane_q     <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         validOut_q <= validOut_d;
         memData_q  <= memData_d;
         misalign_q <= misalign_d;
         busErr_q   <= busErr_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         funct3_q   <= funct3_d;
         lane_q     <= lane_d;
      end
   end

   assign valid_out  = validOut_q;
   assign mem_data   = memData_q;
   assign misalign   = misalign_q;
   assign bus_err    = busErr_q;
   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_be    = be_q;
   assign dmem_wdata = wdata_q;

endmodule
